// File: rtl/sigfmd_seq.sv
// Sequencer for a shared multiplier tree: plain multiply, or Newton-Raphson divide
// (table seed, 2 or 3 refinement iterations, quotient and remainder-check products).
module sigfmd_seq #(
  parameter int unsigned MUL_MIN_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       fdiv,
  input  logic       db,
  input  logic       mul_rdy,
  output logic       mul_go,
  output logic [2:0] sel_a,
  output logic       sel_b,
  output logic       ld_x,
  output logic       ld_t,
  output logic       ld_e,
  output logic       ld_eb,
  output logic       x_tab,
  output logic [1:0] oe1,
  output logic       oe2,
  output logic [1:0] dcnt,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CntW = $clog2(MUL_MIN_LAT + 2);
  localparam logic [CntW-1:0] LatMin = CntW'(MUL_MIN_LAT);

  typedef enum logic [2:0] {
    StIdle, StTab, StNr1, StNr2, StQa, StEb, StMul, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] lat_q, lat_d;
  logic [1:0]      dcnt_q, dcnt_d;
  logic            fdiv_q, fdiv_d;
  logic            go_q, go_d;
  logic            is_mul, accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lat_q   <= '0;
      dcnt_q  <= '0;
      fdiv_q  <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      dcnt_q  <= dcnt_d;
      fdiv_q  <= fdiv_d;
      go_q    <= go_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    fdiv_d  = fdiv_q;
    is_mul  = state_q inside {StNr1, StNr2, StQa, StEb, StMul};
    // lat_q counts cycles since mul_go; earlier ready pulses are stale.
    accept  = is_mul && mul_rdy && (lat_q >= LatMin);

    case (state_q)
      StIdle: begin
        if (start) begin
          fdiv_d  = fdiv;
          dcnt_d  = db ? 2'd3 : 2'd2;
          state_d = fdiv ? StTab : StMul;
        end
      end
      StTab:  state_d = StNr1;
      StNr1:  if (accept) state_d = StNr2;
      StNr2: begin
        if (accept) begin
          if (dcnt_q != 2'd0) dcnt_d = dcnt_q - 2'd1;
          state_d = (dcnt_q <= 2'd1) ? StQa : StNr1;
        end
      end
      StQa:   if (accept) state_d = StEb;
      StEb:   if (accept) state_d = StDone;
      StMul:  if (accept) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    go_d = (state_d != state_q) && (state_d inside {StNr1, StNr2, StQa, StEb, StMul});

    if (state_d != state_q) begin
      lat_d = '0;
    end else if (is_mul && (lat_q < LatMin)) begin
      lat_d = lat_q + 1'b1;
    end else begin
      lat_d = lat_q;
    end
  end

  always_comb begin
    mul_go = go_q;
    sel_a  = 3'd0;
    sel_b  = 1'b0;
    ld_x   = 1'b0;
    ld_t   = 1'b0;
    ld_e   = 1'b0;
    ld_eb  = 1'b0;
    x_tab  = 1'b0;
    oe1    = 2'b00;
    oe2    = 1'b0;
    done   = 1'b0;
    busy   = (state_q != StIdle);
    dcnt   = dcnt_q;

    case (state_q)
      StTab: begin
        ld_x  = 1'b1;
        x_tab = 1'b1;
        oe1   = 2'b11;
      end
      StNr1: begin
        sel_a = 3'd2;
        ld_t  = accept;
        oe1   = 2'b10;
        oe2   = 1'b1;
      end
      StNr2: begin
        sel_a = 3'd3;
        sel_b = 1'b1;
        ld_x  = accept;
        oe1   = 2'b10;
        oe2   = 1'b1;
      end
      StQa: begin
        sel_b = 1'b1;
        ld_e  = accept;
        oe1   = 2'b01;
        oe2   = fdiv_q;
      end
      StEb: begin
        sel_a = 3'd4;
        ld_eb = accept;
        oe1   = 2'b01;
        oe2   = fdiv_q;
      end
      StMul: begin
        ld_e = accept;
        oe1  = 2'b01;
        oe2  = fdiv_q;
      end
      StDone: done = 1'b1;
      default: ;
    endcase

    // Nothing may load or launch in a cycle whose edge is being reset.
    if (rst) begin
      mul_go = 1'b0;
      ld_x   = 1'b0;
      ld_t   = 1'b0;
      ld_e   = 1'b0;
      ld_eb  = 1'b0;
      x_tab  = 1'b0;
      done   = 1'b0;
    end
  end

endmodule

// File: tb/tb_sigfmd_seq.sv
// Directed bench for sigfmd_seq: per-cycle vector table plus multi-cycle operation runs.
module tb_sigfmd_seq;

  logic       clk = 1'b0;
  logic       rst, start, fdiv, db, mul_rdy;
  logic       mul_go, sel_b, ld_x, ld_t, ld_e, ld_eb, x_tab, oe2, busy, done;
  logic [2:0] sel_a;
  logic [1:0] oe1, dcnt;

  int n_chk  = 0;
  int n_pass = 0;

  sigfmd_seq #(.MUL_MIN_LAT(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .fdiv   (fdiv),
    .db     (db),
    .mul_rdy(mul_rdy),
    .mul_go (mul_go),
    .sel_a  (sel_a),
    .sel_b  (sel_b),
    .ld_x   (ld_x),
    .ld_t   (ld_t),
    .ld_e   (ld_e),
    .ld_eb  (ld_eb),
    .x_tab  (x_tab),
    .oe1    (oe1),
    .oe2    (oe2),
    .dcnt   (dcnt),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  logic [16:0] act_vec;
  assign act_vec = {mul_go, sel_a, sel_b, ld_x, ld_t, ld_e, ld_eb, x_tab, oe1, oe2, dcnt, busy,
                    done};

  typedef struct packed {
    logic        start;
    logic        fdiv;
    logic        db;
    logic        rdy;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[22];

  function automatic logic [16:0] e(input logic go, input logic [2:0] sa, input logic sb,
                                    input logic lx, input logic lt, input logic le,
                                    input logic leb, input logic xt, input logic [1:0] o1,
                                    input logic o2, input logic [1:0] dc, input logic bz,
                                    input logic dn);
    return {go, sa, sb, lx, lt, le, leb, xt, o1, o2, dc, bz, dn};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One operation: start at cycle 0, spurious starts every third cycle, multiplier answers
  // 1 cycle after go (or 1-7 with ready also high in the go cycle when rnd).
  task automatic run_op(input logic f, input logic d, input bit rnd, input string tag);
    int go_n = 0, ldx_n = 0, loads = 0, done_cyc = -1, extra_done = 0, bad = 0;
    int wait_cnt = 0;
    bit pend = 0;
    int exp_q[$];
    int got_q[$];
    int exp_go;
    if (f) begin
      exp_q.push_back(0);
      repeat (d ? 3 : 2) begin
        exp_q.push_back(1);
        exp_q.push_back(0);
      end
      exp_q.push_back(2);
      exp_q.push_back(3);
    end else begin
      exp_q.push_back(2);
    end
    exp_go = f ? (d ? 8 : 6) : 1;
    for (int i = 0; i < 300 && done_cyc < 0; i++) begin
      @(posedge clk);
      #1;
      start = (i == 0) || (i % 3 == 2);
      fdiv  = (i == 0) ? f : ~f;
      db    = (i == 0) ? d : ~d;
      if (mul_go) begin
        wait_cnt = rnd ? int'($urandom_range(1, 7)) : 1;
        pend     = 1;
        mul_rdy  = rnd;
      end else if (pend) begin
        wait_cnt--;
        mul_rdy = (wait_cnt == 0);
        if (wait_cnt == 0) pend = 0;
      end else begin
        mul_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(negedge clk);
      if (mul_go) go_n++;
      if (ld_x) got_q.push_back(0);
      if (ld_t) got_q.push_back(1);
      if (ld_e) got_q.push_back(2);
      if (ld_eb) got_q.push_back(3);
      if (ld_x && !x_tab) ldx_n++;
      if (ld_t || (ld_x && !x_tab) || ld_e || ld_eb) loads++;
      if (done) done_cyc = i;
    end
    start   = 1'b0;
    mul_rdy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    if (got_q.size() != exp_q.size()) bad++;
    else foreach (exp_q[k]) if (got_q[k] != exp_q[k]) bad++;
    chk({tag, "_go_count"}, go_n, exp_go);
    chk({tag, "_nr2_ldx"}, ldx_n, f ? (d ? 3 : 2) : 0);
    chk({tag, "_loads"}, loads, exp_go);
    chk({tag, "_strobe_order"}, bad, 0);
    chk({tag, "_extra_done"}, extra_done, 0);
    chk({tag, "_idle_after"}, {31'b0, busy}, 0);
    if (!rnd) chk({tag, "_latency"}, done_cyc, f ? (d ? 18 : 14) : 3);
    else chk({tag, "_finished"}, {31'b0, done_cyc >= 0}, 1);
  endtask

  initial begin
    bit found;
    int nr2_seen;
    // Single divide with early/stray ready and ignored starts, then a double-precision multiply.
    tbl[0]  = '{1, 1, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{0, 1, 0, 1, e(0, 0, 0, 1, 0, 0, 0, 1, 3, 0, 2, 1, 0)};
    tbl[2]  = '{0, 1, 0, 1, e(1, 2, 0, 0, 0, 0, 0, 0, 2, 1, 2, 1, 0)};
    tbl[3]  = '{0, 1, 0, 1, e(0, 2, 0, 0, 1, 0, 0, 0, 2, 1, 2, 1, 0)};
    tbl[4]  = '{1, 0, 1, 0, e(1, 3, 1, 0, 0, 0, 0, 0, 2, 1, 2, 1, 0)};
    tbl[5]  = '{0, 0, 0, 1, e(0, 3, 1, 1, 0, 0, 0, 0, 2, 1, 2, 1, 0)};
    tbl[6]  = '{0, 0, 0, 0, e(1, 2, 0, 0, 0, 0, 0, 0, 2, 1, 1, 1, 0)};
    tbl[7]  = '{0, 0, 0, 1, e(0, 2, 0, 0, 1, 0, 0, 0, 2, 1, 1, 1, 0)};
    tbl[8]  = '{0, 0, 0, 0, e(1, 3, 1, 0, 0, 0, 0, 0, 2, 1, 1, 1, 0)};
    tbl[9]  = '{0, 0, 0, 1, e(0, 3, 1, 1, 0, 0, 0, 0, 2, 1, 1, 1, 0)};
    tbl[10] = '{0, 0, 0, 0, e(1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0)};
    tbl[11] = '{0, 0, 0, 1, e(0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0)};
    tbl[12] = '{0, 0, 0, 0, e(1, 4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0)};
    tbl[13] = '{0, 0, 0, 1, e(0, 4, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 0)};
    tbl[14] = '{1, 1, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)};
    tbl[15] = '{0, 0, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[16] = '{1, 0, 1, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[17] = '{0, 1, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 1, 0)};
    tbl[18] = '{0, 1, 0, 1, e(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 3, 1, 0)};
    tbl[19] = '{1, 0, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 1)};
    tbl[20] = '{0, 0, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0)};
    tbl[21] = '{0, 0, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0)};

    rst = 1'b1; start = 1'b1; fdiv = 1'b1; db = 1'b1; mul_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; mul_rdy = 1'b0;
    @(negedge clk);
    chk("reset_state", {15'b0, act_vec}, 0);

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      start   = tbl[i].start;
      fdiv    = tbl[i].fdiv;
      db      = tbl[i].db;
      mul_rdy = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {15'b0, act_vec}, {15'b0, tbl[i].exp});
    end

    run_op(1'b1, 1'b0, 1'b0, "sdiv");
    run_op(1'b1, 1'b1, 1'b0, "ddiv");
    run_op(1'b0, 1'b0, 1'b0, "mul");
    run_op(1'b1, 1'b1, 1'b1, "ddiv_rnd");
    run_op(1'b1, 1'b0, 1'b1, "sdiv_rnd");
    run_op(1'b0, 1'b1, 1'b1, "mul_rnd");

    // Reset landing on the second NR2 go cycle of a double divide, ready held high.
    found = 0;
    nr2_seen = 0;
    @(posedge clk);
    #1;
    start = 1'b1; fdiv = 1'b1; db = 1'b1; mul_rdy = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (mul_go && sel_a == 3'd3) begin
        nr2_seen++;
        if (nr2_seen == 2) begin
          found = 1;
          rst = 1'b1;
        end
      end
    end
    chk("rst_reached_nr2", {31'b0, found}, 1);
    @(negedge clk);
    chk("rst_cycle_strobes", {27'b0, mul_go, ld_x, ld_t, ld_e, ld_eb}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; mul_rdy = 1'b0;
    @(negedge clk);
    chk("after_rst_outputs", {15'b0, act_vec}, 0);
    run_op(1'b1, 1'b0, 1'b0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sigfmd_seq.md
SIGFMD_SEQ -- requirements
Module: sigfmd_seq

Interface
REQ-001 Parameter MUL_MIN_LAT, default 1, minimum multiplier latency in cycles; mul_rdy earlier than this is ignored.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 fdiv  input  1  1 = divide (Newton-Raphson), 0 = multiply; latched on accepted start.
REQ-006 db  input  1  1 = double precision, 0 = single; latched on accepted start.
REQ-007 mul_rdy  input  1  multiplier tree result valid.
REQ-008 mul_go  output  1  one-cycle pulse launching a multiply with current selects.
REQ-009 sel_a  output  3  operand A select: 0 {fa,5'b0}; 2 x register; 3 ~t high part (2-bx); 4 E register, low 29 bits masked by db.
REQ-010 sel_b  output  1  operand B select: 0 {fb,5'b0}; 1 x register.
REQ-011 ld_x / ld_t / ld_e / ld_eb  output  1 each  one-cycle load strobes for datapath registers.
REQ-012 x_tab  output  1  with ld_x, x loads {2'b01, rom[fb[51:44]], 48'b0} instead of the product.
REQ-013 oe1  output  2  phase code to datapath; oe2  output  1  phase qualifier.
REQ-014 dcnt  output  2  remaining Newton iterations.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse, result registers valid.

Function
REQ-017 States: IDLE, TAB, NR1, NR2, QA, EB, MUL, DONE; one-hot or binary, registered.
REQ-018 IDLE: start&fdiv -> TAB; start&~fdiv -> MUL; latch fdiv, db; load dcnt = db ? 3 : 2.
REQ-019 TAB: one cycle; ld_x=1, x_tab=1; -> NR1.
REQ-020 Mul states (NR1, NR2, QA, EB, MUL): mul_go=1 in the first cycle only; wait for mul_rdy at least MUL_MIN_LAT cycles after go; the accepting cycle asserts that state's load strobe and transitions.
REQ-021 NR1: sel_a=2, sel_b=0 (x*b); accept -> ld_t, -> NR2.
REQ-022 NR2: sel_a=3, sel_b=1 (x*(2-bx)); accept -> ld_x (x_tab=0), dcnt-1; -> QA if dcnt was 1, else NR1.
REQ-023 QA: sel_a=0, sel_b=1 (a*x); accept -> ld_e, -> EB.
REQ-024 EB: sel_a=4, sel_b=0 (E*b); accept -> ld_eb, -> DONE.
REQ-025 MUL: sel_a=0, sel_b=0; accept -> ld_e, -> DONE.
REQ-026 DONE: done=1 one cycle; -> IDLE; start in DONE ignored.
REQ-027 oe1/oe2: IDLE, DONE 00/0; TAB 11/0; NR1, NR2 10/1; QA, EB 01/1; MUL 01/0.
REQ-028 All strobes, mul_go and done are 0 outside their specified cycles; sel_a/sel_b are 0 in non-multiply states.
REQ-029 dcnt never wraps; a decrement is issued only from NR2 with dcnt>=1.
REQ-030 start while busy is ignored; latched fdiv/db are stable for the whole operation.
REQ-031 mul_rdy in IDLE, TAB, DONE is ignored.
REQ-032 Latency with mul_rdy exactly 1 cycle after mul_go: done 14 cycles after accepted start (single divide), 18 (double divide), 3 (multiply).

Reset
REQ-033 rst=1 at any edge, including mid-operation, forces IDLE at that edge with busy, done, mul_go, all ld_*, x_tab, sel_a, sel_b, oe1, oe2, dcnt = 0.
REQ-034 rst has priority over start; no strobe issues in the reset cycle or the cycle after.

Verification
REQ-035 Single divide, rdy 1 cycle after go: start, fdiv=1, db=0 -> TAB, NR1/NR2 x2, QA, EB; 6 mul_go pulses; done at cycle 14; dcnt 2->1->0.
REQ-036 Double divide, same rdy timing -> 8 mul_go pulses, 3 NR2 ld_x strobes, done at cycle 18, oe1 sequence 11,10,01,00.
REQ-037 Multiply, fdiv=0 -> one mul_go with sel_a=0, sel_b=0, ld_e, done at cycle 3, oe1=01, oe2=0 in MUL.
REQ-038 Random mul_rdy delay 1-7 cycles plus mul_rdy held high in go cycle -> early rdy ignored, strobe order unchanged, exactly one load per multiply.
REQ-039 rst asserted in NR2 of a double divide -> all outputs 0 next cycle; new start then completes normally.
REQ-040 start pulsed during busy and in DONE -> ignored; exactly one done per accepted start.
